// File: rtl/riscv_pkg.sv
// Shared types and constants for the pipeline sequencing logic.
package riscv_pkg;

    typedef enum logic [1:0] {
        LOAD_HDR,
        LOAD_BODY,
        RUN,
        HALT
    } pipe_state_e;

    typedef struct packed {
        logic pc_write;
        logic pc_src;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_bubble;
    } hazard_ctrl_type;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/boot_loader.sv
// UART boot image loader: little-endian header word count, then N words
// written to instruction memory; words beyond memory depth are dropped.
module boot_loader #(
    parameter int unsigned IMEM_AW = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hdr_active,
    input  logic               body_active,
    input  logic               uart_valid,
    input  logic [7:0]         uart_byte,
    output logic               hdr_last,
    output logic               hdr_zero,
    output logic               body_last,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_waddr,
    output logic [31:0]        imem_wdata
);

    localparam logic [32:0] DEPTH = 33'd1 << IMEM_AW;

    logic [1:0]         idx_q, idx_d;
    logic [23:0]        shift_q, shift_d;
    logic [31:0]        count_q, count_d;
    logic [31:0]        words_q, words_d;
    logic               we_q, we_d;
    logic [IMEM_AW-1:0] waddr_q, waddr_d;
    logic [31:0]        wdata_q, wdata_d;

    logic        accept;
    logic        word_last;
    logic [31:0] word;

    assign accept    = uart_valid && (hdr_active || body_active);
    assign word_last = accept && (idx_q == 2'd3);
    assign word      = {uart_byte, shift_q};
    assign hdr_last  = word_last && hdr_active;
    assign hdr_zero  = (word == '0);
    assign body_last = word_last && body_active && ((words_q + 32'd1) == count_q);

    always_comb begin
        idx_d   = idx_q;
        shift_d = shift_q;
        count_d = count_q;
        words_d = words_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (accept) begin
            idx_d   = idx_q + 2'd1;
            shift_d = {uart_byte, shift_q[23:8]};
        end
        if (word_last && hdr_active) begin
            count_d = word;
            words_d = '0;
        end else if (word_last && body_active) begin
            words_d = words_q + 32'd1;
            // Out-of-range words still advance the count so the image length is honoured.
            if ({1'b0, words_q} < DEPTH) begin
                we_d    = 1'b1;
                waddr_d = words_q[IMEM_AW-1:0];
                wdata_d = word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            shift_q <= '0;
            count_q <= '0;
            words_q <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            idx_q   <= idx_d;
            shift_q <= shift_d;
            count_q <= count_d;
            words_q <= words_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_waddr = waddr_q;
    assign imem_wdata = wdata_q;

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline run-state FSM, load-use/branch/halt control and optional perf
// counters (enabled by PIPELINE_CONTROLLER_PERF_EN).
module pipeline_controller
    import riscv_pkg::*;
#(
    parameter int unsigned IMEM_AW = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               uart_valid,
    input  logic [7:0]         uart_byte,
    input  logic [4:0]         id_rs1,
    input  logic [4:0]         id_rs2,
    input  logic               id_uses_rs1,
    input  logic               id_uses_rs2,
    input  logic               id_branch_taken,
    input  logic               id_halt,
    input  logic               id_ex_memread,
    input  logic [4:0]         id_ex_rd,
    output logic               pc_write,
    output logic               pc_src,
    output logic               if_id_write,
    output logic               if_id_flush,
    output logic               id_ex_bubble,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_waddr,
    output logic [31:0]        imem_wdata,
    output logic               running,
    output logic               halted,
    output logic [31:0]        stall_count,
    output logic [31:0]        flush_count
);

    pipe_state_e     state_q, state_d;
    logic            running_q, halted_q;
    logic            hdr_last, hdr_zero, body_last;
    logic            load_use;
    hazard_ctrl_type ctrl;

    boot_loader #(.IMEM_AW(IMEM_AW)) u_boot (
        .clk        (clk),
        .rst        (rst),
        .hdr_active (state_q == LOAD_HDR),
        .body_active(state_q == LOAD_BODY),
        .uart_valid (uart_valid),
        .uart_byte  (uart_byte),
        .hdr_last   (hdr_last),
        .hdr_zero   (hdr_zero),
        .body_last  (body_last),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata)
    );

    always_comb begin
        load_use = id_ex_memread && (id_ex_rd != '0) &&
                   ((id_uses_rs1 && (id_rs1 == id_ex_rd)) ||
                    (id_uses_rs2 && (id_rs2 == id_ex_rd)));
        state_d  = state_q;
        ctrl     = '{pc_write: 1'b0, pc_src: 1'b0, if_id_write: 1'b0,
                     if_id_flush: 1'b1, id_ex_bubble: 1'b1};
        unique case (state_q)
            LOAD_HDR:  if (hdr_last) state_d = hdr_zero ? RUN : LOAD_BODY;
            LOAD_BODY: if (body_last) state_d = RUN;
            RUN: begin
                // A stall masks halt and branch; ID re-evaluates them next cycle.
                if (load_use) begin
                    ctrl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
                end else if (id_halt) begin
                    ctrl    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
                    state_d = HALT;
                end else if (id_branch_taken) begin
                    ctrl = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
                end else begin
                    ctrl = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
                end
            end
            HALT:    ctrl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
            default: state_d = LOAD_HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= LOAD_HDR;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= (state_d == RUN);
            halted_q  <= (state_d == HALT);
        end
    end

    assign pc_write     = ctrl.pc_write;
    assign pc_src       = ctrl.pc_src;
    assign if_id_write  = ctrl.if_id_write;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_bubble = ctrl.id_ex_bubble;
    assign running      = running_q;
    assign halted       = halted_q;

`ifdef PIPELINE_CONTROLLER_PERF_EN
    logic [31:0] stall_q, flush_q;
    logic        stall_ev, flush_ev;

    assign stall_ev = (state_q == RUN) && load_use;
    assign flush_ev = (state_q == RUN) && !load_use && !id_halt && id_branch_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_ev && (stall_q != '1)) stall_q <= stall_q + 32'd1;
            if (flush_ev && (flush_q != '1)) flush_q <= flush_q + 32'd1;
        end
    end

    assign stall_count = stall_q;
    assign flush_count = flush_q;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller against a spec-level model.
module tb_pipeline_controller;

    localparam int unsigned AW = 3;
`ifdef PIPELINE_CONTROLLER_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          uart_valid = 1'b0;
    logic [7:0]    uart_byte = '0;
    logic [4:0]    id_rs1 = '0, id_rs2 = '0, id_ex_rd = '0;
    logic          id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
    logic          id_branch_taken = 1'b0, id_halt = 1'b0, id_ex_memread = 1'b0;
    logic          pc_write, pc_src, if_id_write, if_id_flush, id_ex_bubble;
    logic          imem_we, running, halted;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata, stall_count, flush_count;

    int unsigned   vectors = 0;
    int unsigned   miscompares = 0;
    int unsigned   mode = 0;          // 0 = loading, 1 = running, 2 = halted
    int unsigned   stall_m = 0, flush_m = 0;

    logic [AW-1:0] log_a [$];
    logic [31:0]   log_d [$];

    pipeline_controller #(.IMEM_AW(AW)) dut (
        .clk(clk), .rst(rst), .uart_valid(uart_valid), .uart_byte(uart_byte),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_branch_taken(id_branch_taken), .id_halt(id_halt), .id_ex_memread(id_ex_memread),
        .id_ex_rd(id_ex_rd), .pc_write(pc_write), .pc_src(pc_src), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .imem_we(imem_we),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .running(running), .halted(halted),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (imem_we === 1'b1) begin
        log_a.push_back(imem_waddr);
        log_d.push_back(imem_wdata);
    end

    // Expected {pc_write, pc_src, if_id_write, if_id_flush, id_ex_bubble}.
    function automatic logic [4:0] exp_ctrl(input int unsigned m, input bit hz, input bit hlt, input bit br);
        if (m == 0) return 5'b00011;
        if (m == 2) return 5'b00001;
        if (hz)     return 5'b00001;
        if (hlt)    return 5'b00000;
        if (br)     return 5'b11110;
        return 5'b10100;
    endfunction

    function automatic bit hazard_now();
        return id_ex_memread && (id_ex_rd != 0) &&
               ((id_uses_rs1 && id_rs1 == id_ex_rd) || (id_uses_rs2 && id_rs2 == id_ex_rd));
    endfunction

    task automatic drive_id(input bit mr, input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                            input bit u1, input bit u2, input bit br, input bit hlt);
        id_ex_memread = mr; id_ex_rd = rd; id_rs1 = r1; id_rs2 = r2;
        id_uses_rs1 = u1; id_uses_rs2 = u2; id_branch_taken = br; id_halt = hlt;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; uart_valid = 1'b0;
        drive_id(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        mode = 0; stall_m = 0; flush_m = 0;
        log_a.delete(); log_d.delete();
    endtask

    // Leaves time at #1 after the edge that accepted the final byte.
    task automatic send_bytes(input logic [7:0] b [$], input int unsigned max_gap);
        for (int unsigned i = 0; i < b.size(); i++) begin
            uart_valid = 1'b1; uart_byte = b[i];
            @(posedge clk); #1;
            uart_valid = 1'b0;
            if (i + 1 < b.size()) repeat ($urandom_range(max_gap, 0)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic send_image(input logic [31:0] n, input logic [31:0] w [$], input int unsigned max_gap);
        logic [7:0] b [$];
        for (int unsigned i = 0; i < 4; i++) b.push_back(n[8*i +: 8]);
        foreach (w[k]) for (int unsigned i = 0; i < 4; i++) b.push_back(w[k][8*i +: 8]);
        send_bytes(b, max_gap);
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({imem_we, imem_waddr, imem_wdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_imem: got we=%0b addr=%0h data=%0h, expected all zero", imem_we, imem_waddr, imem_wdata);
        end
        vectors++;
        if ({running, halted} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_state: got running=%0b halted=%0b, expected 0 0", running, halted);
        end
        vectors++;
        if ({stall_count, flush_count} !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_counters: got %0h %0h, expected 0 0", stall_count, flush_count);
        end
        vectors++;
        if ({pc_write, pc_src, if_id_write, if_id_flush, id_ex_bubble} !== 5'b00011) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %05b expected 00011", {pc_write, pc_src, if_id_write, if_id_flush, id_ex_bubble});
        end
    endtask

    task automatic test_boot_example();
        logic [31:0] w [$];
        do_reset();
        w.push_back(32'h0000_0013); w.push_back(32'h0010_0093);
        send_image(32'd2, w, 0);
        vectors++;
        if ({running, imem_we} !== 2'b11) begin
            miscompares++;
            $display("FAIL boot_example_run: got running=%0b we=%0b expected 1 1", running, imem_we);
        end
        mode = 1;
        @(negedge clk); #1;
        vectors++;
        if (log_a.size() != 2 || log_a[0] !== 3'd0 || log_d[0] !== 32'h13 ||
            log_a[1] !== 3'd1 || log_d[1] !== 32'h0010_0093) begin
            miscompares++;
            $display("FAIL boot_example_writes: got %0d writes, expected (0,00000013) (1,00100093)", log_a.size());
        end
    endtask

    task automatic test_empty_header();
        logic [31:0] w [$];
        do_reset();
        send_image(32'd0, w, 1);
        vectors++;
        if (running !== 1'b1) begin
            miscompares++;
            $display("FAIL empty_header_run: got running=%0b expected 1", running);
        end
        mode = 1;
        repeat (3) @(posedge clk); #1;
        vectors++;
        if (log_a.size() != 0) begin
            miscompares++;
            $display("FAIL empty_header_writes: got %0d writes expected 0", log_a.size());
        end
    endtask

    task automatic test_boot_random();
        logic [31:0] w [$];
        int unsigned exp_n;
        do_reset();
        for (int unsigned i = 0; i < 10; i++) w.push_back($urandom);
        send_image(32'd10, w, 2);
        vectors++;
        if (running !== 1'b1) begin
            miscompares++;
            $display("FAIL boot_random_run: got running=%0b expected 1", running);
        end
        mode = 1;
        repeat (2) @(posedge clk); #1;
        exp_n = 1 << AW;
        vectors++;
        if (log_a.size() != exp_n) begin
            miscompares++;
            $display("FAIL boot_random_count: got %0d writes expected %0d", log_a.size(), exp_n);
        end
        for (int unsigned i = 0; i < exp_n && i < log_a.size(); i++) begin
            vectors++;
            if (log_a[i] !== i[AW-1:0] || log_d[i] !== w[i]) begin
                miscompares++;
                $display("FAIL boot_random_word%0d: got (%0h,%08h) expected (%0h,%08h)", i, log_a[i], log_d[i], i, w[i]);
            end
        end
    endtask

    task automatic test_load_use();
        logic [4:0] got, exp;
        bit hz, br;
        do_reset();
        begin logic [31:0] w [$]; send_image(32'd0, w, 0); end
        mode = 1;
        for (int unsigned k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            case (k)
                0: drive_id(1, 5, 0, 5, 0, 1, 0, 0);
                1: drive_id(0, 5, 0, 5, 0, 1, 0, 0);
                default: drive_id(1, 0, 0, 0, 0, 1, 0, 0);
            endcase
            @(negedge clk);
            got = {pc_write, pc_src, if_id_write, if_id_flush, id_ex_bubble};
            exp = (k == 0) ? 5'b00001 : 5'b10100;
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL load_use_directed%0d: got %05b expected %05b", k, got, exp);
            end
            if (k == 0) stall_m++;
        end
        for (int unsigned k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            drive_id($urandom_range(1, 0), 5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)),
                     5'($urandom_range(3, 0)), $urandom_range(1, 0), $urandom_range(1, 0),
                     $urandom_range(1, 0), 0);
            @(negedge clk);
            hz = hazard_now(); br = id_branch_taken;
            got = {pc_write, pc_src, if_id_write, if_id_flush, id_ex_bubble};
            exp = exp_ctrl(mode, hz, 0, br);
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL load_use_random%0d: got %05b expected %05b", k, got, exp);
            end
            vectors++;
            if (stall_count !== (PERF ? stall_m : 0) || flush_count !== (PERF ? flush_m : 0)) begin
                miscompares++;
                $display("FAIL perf_counters%0d: got %0d %0d expected %0d %0d", k, stall_count, flush_count,
                         PERF ? stall_m : 0, PERF ? flush_m : 0);
            end
            if (hz) stall_m++;
            else if (br) flush_m++;
        end
    endtask

    task automatic test_priority();
        logic [4:0] got;
        do_reset();
        begin logic [31:0] w [$]; send_image(32'd0, w, 0); end
        mode = 1;
        drive_id(1, 5, 0, 5, 0, 1, 1, 0);
        @(negedge clk);
        got = {pc_write, pc_src, if_id_write, if_id_flush, id_ex_bubble};
        vectors++;
        if (got !== 5'b00001) begin
            miscompares++;
            $display("FAIL priority_stall: got %05b expected 00001", got);
        end
        @(posedge clk); #1;
        drive_id(0, 5, 0, 5, 0, 1, 1, 0);
        @(negedge clk);
        got = {pc_write, pc_src, if_id_write, if_id_flush, id_ex_bubble};
        vectors++;
        if (got !== 5'b11110) begin
            miscompares++;
            $display("FAIL priority_branch: got %05b expected 11110", got);
        end
        @(posedge clk); #1;
        drive_id(0, 0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (stall_count !== (PERF ? 32'd1 : 32'd0) || flush_count !== (PERF ? 32'd1 : 32'd0)) begin
            miscompares++;
            $display("FAIL priority_counters: got %0d %0d expected %0d %0d", stall_count, flush_count, PERF, PERF);
        end
    endtask

    task automatic test_halt();
        logic [31:0] w [$];
        logic [4:0]  got;
        do_reset();
        w.push_back($urandom); w.push_back($urandom);
        send_image(32'd2, w, 1);
        mode = 1;
        @(posedge clk); #1;
        drive_id(0, 0, 0, 0, 0, 0, 0, 1);
        @(posedge clk); #1;
        mode = 2;
        vectors++;
        if ({halted, running} !== 2'b10) begin
            miscompares++;
            $display("FAIL halt_entry: got halted=%0b running=%0b expected 1 0", halted, running);
        end
        for (int unsigned k = 0; k < 100; k++) begin
            drive_id($urandom_range(1, 0), 5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)),
                     5'($urandom_range(3, 0)), $urandom_range(1, 0), $urandom_range(1, 0),
                     $urandom_range(1, 0), $urandom_range(1, 0));
            uart_valid = $urandom_range(1, 0); uart_byte = 8'($urandom);
            @(negedge clk);
            got = {pc_write, pc_src, if_id_write, if_id_flush, id_ex_bubble};
            vectors++;
            if (got !== exp_ctrl(mode, 0, 0, 0) || imem_we !== 1'b0 || halted !== 1'b1) begin
                miscompares++;
                $display("FAIL halt_hold%0d: got ctrl=%05b we=%0b halted=%0b expected 00001 0 1", k, got, imem_we, halted);
            end
            @(posedge clk); #1;
        end
        uart_valid = 1'b0;
        vectors++;
        if (imem_waddr !== 3'd1) begin
            miscompares++;
            $display("FAIL halt_waddr_before_rst: got %0h expected 1", imem_waddr);
        end
        do_reset();
        vectors++;
        if ({running, halted, imem_waddr, pc_write} !== '0) begin
            miscompares++;
            $display("FAIL halt_reset: got running=%0b halted=%0b waddr=%0h pc_write=%0b expected all 0",
                     running, halted, imem_waddr, pc_write);
        end
    endtask

    task automatic test_reset_midload();
        logic [7:0]  b [$];
        logic [31:0] w [$];
        logic [31:0] nw;
        do_reset();
        b = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_bytes(b, 1);
        do_reset();
        nw = $urandom;
        w.push_back(nw);
        send_image(32'd1, w, 1);
        vectors++;
        if (running !== 1'b1) begin
            miscompares++;
            $display("FAIL midload_run: got running=%0b expected 1", running);
        end
        repeat (2) @(posedge clk); #1;
        vectors++;
        if (log_a.size() != 1 || log_a[0] !== 3'd0 || log_d[0] !== nw) begin
            miscompares++;
            $display("FAIL midload_write: got %0d writes first=(%0h,%08h) expected 1 write (0,%08h)",
                     log_a.size(), log_a.size() ? log_a[0] : 3'd0, log_d.size() ? log_d[0] : 32'd0, nw);
        end
    endtask

    initial begin
        test_reset();
        test_boot_example();
        test_empty_header();
        test_boot_random();
        test_load_use();
        test_priority();
        test_halt();
        test_reset_midload();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
